// File: rtl/stream_width_downsizer_if.sv
// Valid/ready bundle for the width downsizer: a wide word goes in, narrow beats come out.
// The master modport drives the word and consumes beats; the slave modport is the downsizer side.
interface stream_width_downsizer_if #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [IN_WIDTH-1:0]  in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_last;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_last
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_last
  );
endinterface

// File: rtl/stream_width_downsizer.sv
// Splits each IN_WIDTH word into IN_WIDTH/OUT_WIDTH beats at full throughput, flagging the last beat.
// Build option DWS_MSB_FIRST_EN: when defined, beats are emitted MSB slice first (default LSB first).
module stream_width_downsizer #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  stream_width_downsizer_if.slave bus
);
  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

  generate
    if ((IN_WIDTH % OUT_WIDTH) != 0 || RATIO < 2) begin : g_bad_params
      $error("stream_width_downsizer: IN_WIDTH must be a multiple of OUT_WIDTH with ratio >= 2");
    end
  endgenerate

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic [IN_WIDTH-1:0]  word_q, word_d;

  logic                 busy;
  logic                 last_beat;
  logic                 accept;
  logic [OUT_WIDTH-1:0] beat_slice [RATIO];

  genvar gi;
  generate
    for (gi = 0; gi < RATIO; gi++) begin : g_slice
`ifdef DWS_MSB_FIRST_EN
      assign beat_slice[gi] = word_q[IN_WIDTH-1-gi*OUT_WIDTH -: OUT_WIDTH];
`else
      assign beat_slice[gi] = word_q[gi*OUT_WIDTH +: OUT_WIDTH];
`endif
    end
  endgenerate

  assign busy          = (state_q == SEND);
  assign last_beat     = busy && (beat_cnt_q == LAST_CNT);
  // A new word may only land on the cycle the last beat leaves, which keeps the output bubble-free.
  assign bus.in_ready  = !busy || (bus.out_ready && last_beat);
  assign accept        = bus.in_valid && bus.in_ready;

  assign bus.out_valid = busy;
  assign bus.out_last  = last_beat;
  assign bus.out_data  = beat_slice[beat_cnt_q];

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    word_d     = word_q;
    if (accept) begin
      word_d     = bus.in_data;
      beat_cnt_d = '0;
      state_d    = SEND;
    end else if (busy && bus.out_ready) begin
      if (last_beat) begin
        // Word finished with nothing queued; word_q is kept as is.
        state_d    = IDLE;
        beat_cnt_d = '0;
      end else begin
        beat_cnt_d = beat_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      word_q     <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      word_q     <= word_d;
    end
  end
endmodule
